// File: rtl/cpu_disp_pkg.sv
// Shared constants, digit index type and hex-to-segment decode for the
// seven-segment display scanner.
package cpu_disp_pkg;

    localparam int         DIGITS    = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [2:0] digit_t;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Scan-rate prescaler: emits a one-cycle tick every SCAN_DIV clocks and
// advances a 3-bit digit index on each tick.
module disp_prescaler
    import cpu_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic   Clock,
    input  logic   Reset,
    output logic   tick_o,
    output digit_t digit_o
);

    localparam int              PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescale_q, prescale_d;
    digit_t        digit_q, digit_d;

    assign tick_o  = (prescale_q == LAST);
    assign digit_o = digit_q;

    always_comb begin
        prescale_d = tick_o ? '0 : prescale_q + PW'(1);
        digit_d    = tick_o ? digit_q + 3'd1 : digit_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prescale_q <= '0;
            digit_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            digit_q    <= digit_d;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Double-buffered 8-digit hex scanner for the syscall display word, with a
// sticky halt indicator on the decimal points.
module seg_display_scanner
    import cpu_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] in_data,
    input  logic        in_load,
    input  logic        in_halt,
    output logic [7:0]  out_an,
    output logic [6:0]  out_seg,
    output logic        out_dp
);

    logic        tick;
    digit_t      digit;
    logic        boundary;

    logic [31:0] shown_q, shown_d;
    logic [31:0] staged_q, staged_d;
    logic        pending_q, pending_d;
    logic        halted_q, halted_d;

    disp_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .Clock   (Clock),
        .Reset   (Reset),
        .tick_o  (tick),
        .digit_o (digit)
    );

    assign boundary = tick && (digit == 3'd7);

    // shown only changes at a frame boundary so a frame never mixes two words;
    // a load landing on the boundary itself bypasses the staging register.
    always_comb begin
        shown_d   = shown_q;
        staged_d  = staged_q;
        pending_d = pending_q;
        halted_d  = halted_q | in_halt;
        if (in_load && boundary) begin
            shown_d   = in_data;
            pending_d = 1'b0;
        end else if (in_load) begin
            staged_d  = in_data;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            shown_d   = staged_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            shown_q   <= '0;
            staged_q  <= '0;
            pending_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            shown_q   <= shown_d;
            staged_q  <= staged_d;
            pending_q <= pending_d;
            halted_q  <= halted_d;
        end
    end

    logic [31:0] upper;
    logic        blank;

    // upper[3:0] is the current nibble; the whole of upper being zero means
    // this digit and everything above it are leading zeros.
    assign upper = shown_q >> {digit, 2'b00};
    assign blank = BLANK_LZ && (digit != 3'd0) && (upper == 32'd0);

    assign out_an  = ~(8'b1 << digit);
    assign out_seg = blank ? SEG_BLANK : hex_to_seg(upper[3:0]);
    assign out_dp  = ~halted_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench: directed scenarios then random loads/halts/resets,
// compared every cycle against a frame-level reference model.
module tb_seg_display_scanner;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        load;
    logic        halt;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg_display_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .in_data (data),
        .in_load (load),
        .in_halt (halt),
        .out_an  (an),
        .out_seg (seg),
        .out_dp  (dp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: cycles since reset plus the word shown / waiting
    int          t;
    logic [31:0] m_shown, m_staged;
    bit          m_pend, m_halted;
    bit          chk_en = 0;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int          d;
        logic [31:0] up;
        logic [6:0]  e_seg;
        d     = (t / SCAN_DIV) % 8;
        up    = m_shown >> (4 * d);
        e_seg = (d != 0 && up == 0) ? 7'h7F : seg_tab[up & 32'hF];
        chk("an",  {24'd0, an},  {24'd0, ~(8'd1 << d)});
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("dp",  {31'd0, dp},  {31'd0, ~m_halted});
    endtask

    // one clock: check outputs, apply inputs, advance the model
    task automatic cyc(input bit r, input bit l, input logic [31:0] dd, input bit h);
        bit bnd;
        @(negedge clk);
        if (chk_en) check_outputs();
        rst = r; load = l; data = dd; halt = h;
        @(posedge clk);
        if (r) begin
            t = 0; m_shown = 0; m_staged = 0; m_pend = 0; m_halted = 0;
            chk_en = 1;
        end else begin
            bnd = (t % FRAME) == FRAME - 1;
            if (l && bnd) begin
                m_shown = dd; m_pend = 0;
            end else if (l) begin
                m_staged = dd; m_pend = 1;
            end else if (bnd && m_pend) begin
                m_shown = m_staged; m_pend = 0;
            end
            if (h) m_halted = 1;
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cyc(0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1; load = 0; data = 0; halt = 0;
        // 1. reset, then a free-running frame plus wrap
        repeat (3) cyc(1, 0, 32'h0, 0);
        idle(FRAME + 2);
        // 2. load early in a frame, commit at the boundary
        idle_until(5);
        cyc(0, 1, 32'h1234ABCD, 0);
        idle(2 * FRAME);
        // 3. last load in a frame wins; leading zeros blanked
        idle_until(2);
        cyc(0, 1, 32'h00000011, 0);
        idle(6);
        cyc(0, 1, 32'h00000F00, 0);
        idle(2 * FRAME);
        // 4. load exactly on the frame boundary beats an older pending word
        idle_until(4);
        cyc(0, 1, 32'h00000001, 0);
        idle_until(FRAME - 1);
        cyc(0, 1, 32'hDEADBEEF, 0);
        idle(2 * FRAME);
        // 5. halt pulse is sticky; reset clears it
        cyc(0, 0, 32'h0, 1);
        idle(FRAME + 3);
        cyc(1, 0, 32'h0, 0);
        idle(10);
        // 6. reset mid-frame discards a pending load
        idle_until(1);
        cyc(0, 1, 32'hFFFFFFFF, 0);
        idle_until(3 * SCAN_DIV);
        cyc(1, 0, 32'h0, 0);
        idle(2 * FRAME);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r, l, h;
            logic [31:0] dd;
            r  = ($urandom_range(0, 599) == 0);
            l  = ($urandom_range(0, 11) == 0);
            h  = ($urandom_range(0, 299) == 0);
            dd = $urandom >> $urandom_range(0, 31);
            cyc(r, l, dd, h);
        end
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
